status_cond_unit: RTL and testbench
===================================

Name: status_cond_unit

Overview:
- Consumer end of the ALU status interface.
- Captures the 4-bit {N,Z,C,V} flags the ALU drives out of EX into the architectural status register when the EX instruction has its S bit set.
- Evaluates the 4-bit ARM condition field of the instruction in ID against those flags, and feeds the registered carry back to the ALU carry input.
- Either bypasses in-flight flags from EX or raises a stall, selected by parameter.

Parameters:
- BYPASS, 1, 1 = ID condition evaluation uses EX flags being written this cycle; 0 = raise condHazard instead.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- statusIn  input  4  ALU flags {N,Z,C,V}, bit3 = N, bit0 = V.
- sUpdate  input  1  EX instruction's S bit.
- exeValid  input  1  EX stage holds a real (non-bubble) instruction.
- freeze  input  1  pipeline hold; blocks status write and bypass.
- flush  input  1  kill the ID instruction (taken branch).
- idValid  input  1  ID stage holds a real instruction.
- condIn  input  4  ID instruction's condition field.
- condPass  output  1  ID instruction may execute.
- condHazard  output  1  stall request (only possible when BYPASS=0).
- statusReg  output  4  architectural {N,Z,C,V}.
- carryOut  output  1  statusReg[1], to the ALU carry input.

Behaviour:
- Write enable: wr = exeValid & sUpdate & ~freeze.
- Register update: on rising clk, rst=1 sets statusReg to 4'b0000. Otherwise, wr=1 loads statusIn; wr=0 holds.
- Reset and timing: reset takes priority over wr in the same cycle. The register updates one cycle after the flags are presented.
- carryOut: combinational from statusReg C bit. The next EX instruction (ADC/SBC) therefore sees the carry of the previous flag-setting instruction with no extra latency.
- Effective flags: effFlags = (BYPASS==1 & wr) ? statusIn : statusReg. All ports other than statusReg are combinational from inputs and statusReg.
- Condition table on effFlags:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (reserved, never executes)
- condHazard = (BYPASS==0) & idValid & ~flush & wr & (condIn != 4'b1110) & (condIn != 4'b1111). Tied 0 when BYPASS=1.
- condPass = idValid & ~flush & ~condHazard & table(condIn, effFlags).
- Simultaneous flush and hazard: flush wins; condHazard=0 and condPass=0.
- freeze=1: no write, no bypass. condPass is evaluated on the held statusReg.
- Reset mid-operation: statusReg clears next edge regardless of wr. A bypass in the reset cycle still shows statusIn combinationally; the stored result is 0.
- No internal state other than statusReg. No X propagation allowed from unused condition codes.

Test Plan:
- Reset: rst=1 for 2 cycles with wr=1, statusIn=4'b1111 -> statusReg=0000, carryOut=0, condIn=0000 with idValid=1 gives condPass=0.
- Flag write: exeValid=1, sUpdate=1, statusIn=4'b0100 -> next cycle statusReg=0100. With sUpdate=0 and statusIn=1010 -> statusReg stays 0100.
- Bypass (BYPASS=1): statusReg=0000, wr=1, statusIn=0100, idValid=1, condIn=0000 -> condPass=1 same cycle, condHazard=0. Sweep all 16 conds × 16 flag values against the table.
- Hazard (BYPASS=0): same stimulus -> condHazard=1, condPass=0. With condIn=1110 -> condHazard=0, condPass=1. Next cycle wr=0 -> condHazard=0, condPass=1.
- Flush/freeze: flush=1 with condIn=1110, idValid=1 -> condPass=0, condHazard=0. freeze=1, wr inputs active, statusIn=0010 -> statusReg unchanged, carryOut unchanged.
- Carry chain: flag write of statusIn=0010 -> next cycle carryOut=1. Then flag write of 0000 -> carryOut=0 following cycle.

Source files
------------

// File: rtl/status_cond_unit_if.sv
// ALU status / condition interface between the pipeline and status_cond_unit.
// The master drives the EX flags and ID condition; the slave returns the verdict and status.
interface status_cond_unit_if;
  logic [3:0] statusIn;
  logic       sUpdate;
  logic       exeValid;
  logic       freeze;
  logic       flush;
  logic       idValid;
  logic [3:0] condIn;
  logic       condPass;
  logic       condHazard;
  logic [3:0] statusReg;
  logic       carryOut;

  modport master (
    output statusIn, sUpdate, exeValid, freeze, flush, idValid, condIn,
    input  condPass, condHazard, statusReg, carryOut
  );

  modport slave (
    input  statusIn, sUpdate, exeValid, freeze, flush, idValid, condIn,
    output condPass, condHazard, statusReg, carryOut
  );
endinterface

// File: rtl/status_cond_unit.sv
// Architectural {N,Z,C,V} status register with ARM condition evaluation for the ID stage.
// BYPASS selects forwarding of in-flight EX flags versus a stall request.
module status_cond_unit #(
  parameter bit BYPASS = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  status_cond_unit_if.slave  bus
);

  logic [3:0] status_r;
  logic [3:0] eff_flags_s;
  logic       wr_s;
  logic       hazard_s;
  logic       table_s;

  function automatic logic cond_table(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic r;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = c;
      4'b0011: r = ~c;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = c & ~z;
      4'b1001: r = ~c | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign wr_s = bus.exeValid & bus.sUpdate & ~bus.freeze;

  // Status register: reset outranks a flag write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_r <= 4'b0000;
    end else if (wr_s) begin
      status_r <= bus.statusIn;
    end else begin
      status_r <= status_r;
    end
  end

  // Flags seen by the ID condition: forwarded from EX only when bypass is built in.
  always_comb begin
    eff_flags_s = status_r;
    if (BYPASS && wr_s) begin
      eff_flags_s = bus.statusIn;
    end else begin
      eff_flags_s = status_r;
    end
  end

  // AL and the reserved code never depend on flags, so they never stall.
  assign hazard_s = (BYPASS == 1'b0) & bus.idValid & ~bus.flush & wr_s &
                    (bus.condIn != 4'b1110) & (bus.condIn != 4'b1111);

  assign table_s        = cond_table(bus.condIn, eff_flags_s);
  assign bus.condHazard = hazard_s;
  assign bus.condPass   = bus.idValid & ~bus.flush & ~hazard_s & table_s;
  assign bus.statusReg  = status_r;
  assign bus.carryOut   = status_r[1];

endmodule

// File: tb/tb_status_cond_unit.sv
// Directed bench for status_cond_unit: one bypassing and one stalling instance share stimulus.
module tb_status_cond_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  status_cond_unit_if if_b ();
  status_cond_unit_if if_h ();

  status_cond_unit #(.BYPASS(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  status_cond_unit #(.BYPASS(1'b0)) dut_h (.clk(clk), .rst(rst), .bus(if_h));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flags;
    logic       pass;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic drive(input logic exe, input logic s, input logic frz, input logic fl,
                       input logic idv, input logic [3:0] cond, input logic [3:0] st);
    if_b.exeValid = exe; if_h.exeValid = exe;
    if_b.sUpdate  = s;   if_h.sUpdate  = s;
    if_b.freeze   = frz; if_h.freeze   = frz;
    if_b.flush    = fl;  if_h.flush    = fl;
    if_b.idValid  = idv; if_h.idValid  = idv;
    if_b.condIn   = cond; if_h.condIn  = cond;
    if_b.statusIn = st;  if_h.statusIn = st;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: predicate per pair, odd codes invert (1111 = ~AL = 0).
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic r;
    case (c[3:1])
      3'd0: r = f[2];
      3'd1: r = f[1];
      3'd2: r = f[3];
      3'd3: r = f[0];
      3'd4: r = f[1] & ~f[2];
      3'd5: r = (f[3] == f[0]);
      3'd6: r = ~f[2] & (f[3] == f[0]);
      default: r = 1'b1;
    endcase
    return r ^ c[0];
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = '{4'b0000, 4'b0100, 1'b1};
    vecs[1]  = '{4'b0000, 4'b0000, 1'b0};
    vecs[2]  = '{4'b0001, 4'b0000, 1'b1};
    vecs[3]  = '{4'b0010, 4'b0010, 1'b1};
    vecs[4]  = '{4'b0011, 4'b0010, 1'b0};
    vecs[5]  = '{4'b0100, 4'b1000, 1'b1};
    vecs[6]  = '{4'b0101, 4'b1000, 1'b0};
    vecs[7]  = '{4'b0110, 4'b0001, 1'b1};
    vecs[8]  = '{4'b0111, 4'b0001, 1'b0};
    vecs[9]  = '{4'b1000, 4'b0010, 1'b1};
    vecs[10] = '{4'b1000, 4'b0110, 1'b0};
    vecs[11] = '{4'b1001, 4'b0110, 1'b1};
    vecs[12] = '{4'b1001, 4'b0010, 1'b0};
    vecs[13] = '{4'b1010, 4'b1001, 1'b1};
    vecs[14] = '{4'b1010, 4'b1000, 1'b0};
    vecs[15] = '{4'b1011, 4'b1000, 1'b1};
    vecs[16] = '{4'b1100, 4'b0000, 1'b1};
    vecs[17] = '{4'b1100, 4'b0100, 1'b0};
    vecs[18] = '{4'b1101, 4'b0001, 1'b1};
    vecs[19] = '{4'b1101, 4'b0000, 1'b0};
    vecs[20] = '{4'b1110, 4'b0000, 1'b1};
    vecs[21] = '{4'b1111, 4'b1111, 1'b0};

    // Reset with an active write pending.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111);
    tick();
    tick();
    check("rst_status_b", if_b.statusReg, 4'b0000);
    check("rst_status_h", if_h.statusReg, 4'b0000);
    check("rst_carry_b", if_b.carryOut, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111);
    check("rst_eq_pass_b", if_b.condPass, 1'b0);
    check("rst_eq_pass_h", if_h.condPass, 1'b0);

    // Flag write and hold.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100);
    tick();
    check("write_status_b", if_b.statusReg, 4'b0100);
    check("write_status_h", if_h.statusReg, 4'b0100);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1010);
    tick();
    check("hold_status_b", if_b.statusReg, 4'b0100);

    // Bypass versus hazard from a cleared register.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0100);
    check("byp_pass_b", if_b.condPass, 1'b1);
    check("byp_haz_b", if_b.condHazard, 1'b0);
    check("haz_haz_h", if_h.condHazard, 1'b1);
    check("haz_pass_h", if_h.condPass, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1110, 4'b0100);
    check("haz_al_haz_h", if_h.condHazard, 1'b0);
    check("haz_al_pass_h", if_h.condPass, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 4'b0100);
    check("haz_nv_haz_h", if_h.condHazard, 1'b0);
    check("haz_nv_pass_h", if_h.condPass, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0100);
    check("after_haz_haz_h", if_h.condHazard, 1'b0);
    check("after_haz_pass_h", if_h.condPass, 1'b1);

    // Flush beats both pass and hazard.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1110, 4'b0000);
    check("flush_al_pass_b", if_b.condPass, 1'b0);
    check("flush_al_pass_h", if_h.condPass, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0100);
    check("flush_haz_h", if_h.condHazard, 1'b0);
    check("flush_pass_b", if_b.condPass, 1'b0);
    tick();

    // Freeze: no write, no bypass (register still 0100).
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0010, 4'b0010);
    check("freeze_cs_pass_b", if_b.condPass, 1'b0);
    check("freeze_haz_h", if_h.condHazard, 1'b0);
    tick();
    check("freeze_status_b", if_b.statusReg, 4'b0100);
    check("freeze_carry_b", if_b.carryOut, 1'b0);

    // Carry chain.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010);
    tick();
    check("carry_set_b", if_b.carryOut, 1'b1);
    check("carry_set_h", if_h.carryOut, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    tick();
    check("carry_clr_b", if_b.carryOut, 1'b0);

    // Reset mid-operation: bypass still visible, stored result is zero.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111);
    check("rst_byp_pass_b", if_b.condPass, 1'b1);
    tick();
    rst = 1'b0;
    check("rst_mid_status_b", if_b.statusReg, 4'b0000);

    // Table vectors: bypass path same cycle, registered path next cycle.
    for (int i = 0; i < 22; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, vecs[i].cond, vecs[i].flags);
      check($sformatf("vec%0d_byp", i), if_b.condPass, vecs[i].pass);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, vecs[i].cond, 4'b0000);
      check($sformatf("vec%0d_reg", i), if_h.condPass, vecs[i].pass);
    end

    // Full sweep on the bypass instance.
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'(c), 4'(f));
        check($sformatf("sweep_c%0d_f%0d", c, f), if_b.condPass, ref_cond(4'(c), 4'(f)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
